// File: rtl/neuron_ctrl_pkg.sv
// Shared types and width helpers for the neuron sequencing controllers.
// Optional bias stage: NEURON_BIAS_ADD_EN.
package neuron_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_INIT = 3'd1,
    S_MULT = 3'd2,
    S_ACC  = 3'd3,
    S_BIAS = 3'd4,
    S_ACT  = 3'd5,
    S_DONE = 3'd6
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int len_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/neuron_seq_controller_if.sv
// Start/config request and datapath strobes of the neuron controller.
// bw exists only when NEURON_BIAS_ADD_EN is defined.
interface neuron_seq_controller_if #(
  parameter int NUM_INPUTS = 4
);
  import neuron_ctrl_pkg::*;

  localparam int IDX_W = idx_w(NUM_INPUTS);
  localparam int LEN_W = len_w(NUM_INPUTS);

  logic             start;
  logic [LEN_W-1:0] cfg_len;
  logic             busy;
  logic [IDX_W-1:0] sel;
  logic             acc_clr;
  logic             mul_en;
  logic             mw;
  logic             aw;
  logic             ow;
  logic             done;
`ifdef NEURON_BIAS_ADD_EN
  logic             bw;
`endif

  modport slave (
    input  start, cfg_len,
    output busy, sel, acc_clr, mul_en,
    output mw, aw, ow, done
`ifdef NEURON_BIAS_ADD_EN
    , output bw
`endif
  );

  modport master (
    output start, cfg_len,
    input  busy, sel, acc_clr, mul_en,
    input  mw, aw, ow, done
`ifdef NEURON_BIAS_ADD_EN
    , input bw
`endif
  );

endinterface

// File: rtl/neuron_term_counter.sv
// Term index with clear/increment and last-term compare against a length.
// Reusable by layer-level controllers.
module neuron_term_counter
  import neuron_ctrl_pkg::*;
#(
  parameter  int NUM_INPUTS = 4,
  localparam int IDX_W      = idx_w(NUM_INPUTS),
  localparam int LEN_W      = len_w(NUM_INPUTS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  input  logic [LEN_W-1:0] len,
  output logic [IDX_W-1:0] idx,
  output logic             last
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (clr) begin
      idx <= '0;
    end else if (inc) begin
      idx <= idx + IDX_W'(1);
    end
  end

  assign last = ((LEN_W'(idx) + LEN_W'(1)) == len);

endmodule

// File: rtl/neuron_seq_controller.sv
// Sequencer for one neuron MAC unit: INIT, per-term MULT/ACC, ACT, DONE.
// Define NEURON_BIAS_ADD_EN to insert a BIAS stage and the bw strobe.
module neuron_seq_controller
  import neuron_ctrl_pkg::*;
#(
  parameter int NUM_INPUTS = 4,
  parameter int MUL_LAT    = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  neuron_seq_controller_if.slave  bus
);

  localparam int IDX_W = idx_w(NUM_INPUTS);
  localparam int LEN_W = len_w(NUM_INPUTS);
  localparam int WC_W  = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  state_t           state;
  state_t           nstate;
  logic [LEN_W-1:0] len_q;
  logic [WC_W-1:0]  wcnt;
  logic             mult_last;
  logic [IDX_W-1:0] idx;
  logic             last;
  logic             clr;
  logic             inc;

  logic             busy_c;
  logic [IDX_W-1:0] sel_c;
  logic             acc_clr_c;
  logic             mul_en_c;
  logic             mw_c;
  logic             aw_c;
  logic             ow_c;
  logic             done_c;
  logic             bw_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      len_q <= '0;
    end else begin
      state <= nstate;
      if (state == S_IDLE && bus.start) begin
        len_q <= (bus.cfg_len > LEN_W'(NUM_INPUTS))
               ? LEN_W'(NUM_INPUTS) : bus.cfg_len;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt <= '0;
    end else if (state == S_MULT && !mult_last) begin
      wcnt <= wcnt + WC_W'(1);
    end else begin
      wcnt <= '0;
    end
  end

  assign mult_last = (wcnt == WC_W'(MUL_LAT - 1));

  assign clr = (state == S_IDLE) || (state == S_INIT) ||
               (state == S_DONE);
  assign inc = (state == S_ACC) && !last;

  neuron_term_counter #(
    .NUM_INPUTS (NUM_INPUTS)
  ) u_term (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (inc),
    .len   (len_q),
    .idx   (idx),
    .last  (last)
  );

  always_comb begin
    nstate    = S_IDLE;
    busy_c    = 1'b1;
    sel_c     = idx;
    acc_clr_c = 1'b0;
    mul_en_c  = 1'b0;
    mw_c      = 1'b0;
    aw_c      = 1'b0;
    ow_c      = 1'b0;
    done_c    = 1'b0;
    bw_c      = 1'b0;
    unique case (state)
      S_IDLE: begin
        busy_c = 1'b0;
        sel_c  = '0;
        nstate = bus.start ? S_INIT : S_IDLE;
      end
      S_INIT: begin
        acc_clr_c = 1'b1;
        if (bus.start) begin
          nstate = S_INIT;
        end else if (len_q == '0) begin
`ifdef NEURON_BIAS_ADD_EN
          nstate = S_BIAS;
`else
          nstate = S_ACT;
`endif
        end else begin
          nstate = S_MULT;
        end
      end
      S_MULT: begin
        mul_en_c = 1'b1;
        mw_c     = mult_last;
        nstate   = mult_last ? S_ACC : S_MULT;
      end
      S_ACC: begin
        aw_c = 1'b1;
`ifdef NEURON_BIAS_ADD_EN
        nstate = last ? S_BIAS : S_MULT;
`else
        nstate = last ? S_ACT : S_MULT;
`endif
      end
`ifdef NEURON_BIAS_ADD_EN
      S_BIAS: begin
        bw_c   = 1'b1;
        nstate = S_ACT;
      end
`endif
      S_ACT: begin
        ow_c   = 1'b1;
        nstate = S_DONE;
      end
      S_DONE: begin
        sel_c  = '0;
        done_c = 1'b1;
        nstate = S_IDLE;
      end
      // Unreachable encodings fall back to an idle-looking cycle.
      default: begin
        busy_c = 1'b0;
        sel_c  = '0;
        nstate = S_IDLE;
      end
    endcase
  end

  assign bus.busy    = busy_c;
  assign bus.sel     = sel_c;
  assign bus.acc_clr = acc_clr_c;
  assign bus.mul_en  = mul_en_c;
  assign bus.mw      = mw_c;
  assign bus.aw      = aw_c;
  assign bus.ow      = ow_c;
  assign bus.done    = done_c;
`ifdef NEURON_BIAS_ADD_EN
  assign bus.bw      = bw_c;
`else
  logic unused_bw;
  assign unused_bw = bw_c;
`endif

endmodule

// File: tb/tb_neuron_seq_controller.sv
// Bench for neuron_seq_controller: two instances (MUL_LAT 1 and 3).
// Expected per-cycle strobe vectors are queued per run and popped per cycle.
module tb_neuron_seq_controller;

  logic clk;
  logic rst_n;
  int   errs;
  int   checks;

  logic [9:0] q[$];

  neuron_seq_controller_if #(.NUM_INPUTS(4)) ifc1 ();
  neuron_seq_controller_if #(.NUM_INPUTS(4)) ifc3 ();

  neuron_seq_controller #(
    .NUM_INPUTS (4),
    .MUL_LAT    (1)
  ) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc1)
  );

  neuron_seq_controller #(
    .NUM_INPUTS (4),
    .MUL_LAT    (3)
  ) u_dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] pk(input logic b, input int s,
                                    input logic c, input logic m,
                                    input logic w, input logic a,
                                    input logic o, input logic d,
                                    input logic bw);
    logic [1:0] s2;
    s2 = s[1:0];
    return {b, s2, c, m, w, a, o, d, bw};
  endfunction

  function automatic logic [9:0] obs(input int w);
    logic bw1;
    logic bw3;
`ifdef NEURON_BIAS_ADD_EN
    bw1 = ifc1.bw;
    bw3 = ifc3.bw;
`else
    bw1 = 1'b0;
    bw3 = 1'b0;
`endif
    if (w == 3)
      return {ifc3.busy, ifc3.sel, ifc3.acc_clr, ifc3.mul_en,
              ifc3.mw, ifc3.aw, ifc3.ow, ifc3.done, bw3};
    return {ifc1.busy, ifc1.sel, ifc1.acc_clr, ifc1.mul_en,
            ifc1.mw, ifc1.aw, ifc1.ow, ifc1.done, bw1};
  endfunction

  task automatic drv(input int w, input logic s, input int len);
    if (w == 3) begin
      ifc3.start   = s;
      ifc3.cfg_len = len[2:0];
    end else begin
      ifc1.start   = s;
      ifc1.cfg_len = len[2:0];
    end
  endtask

  // Expected strobes from the first INIT cycle to the idle cycle after done.
  task automatic expect_run(input int len, input int hold, input int lat);
    int l;
    int li;
    l  = (len > 4) ? 4 : len;
    li = (l == 0) ? 0 : l - 1;
    repeat (hold) q.push_back(pk(1, 0, 1, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < l; k++) begin
      for (int m = 0; m < lat; m++)
        q.push_back(pk(1, k, 0, 1, (m == lat - 1), 0, 0, 0, 0));
      q.push_back(pk(1, k, 0, 0, 0, 1, 0, 0, 0));
    end
`ifdef NEURON_BIAS_ADD_EN
    q.push_back(pk(1, li, 0, 0, 0, 0, 0, 0, 1));
`endif
    q.push_back(pk(1, li, 0, 0, 0, 0, 1, 0, 0));
    q.push_back(pk(1, 0, 0, 0, 0, 0, 0, 1, 0));
    q.push_back(pk(0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic run(input string tag, input int w, input int len,
                     input int hold, input int lat);
    int n;
    logic [9:0] e;
    expect_run(len, hold, lat);
    @(negedge clk);
    drv(w, 1'b1, len);
    n = 0;
    while (q.size() > 0 && n < 64) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      // cfg_len wiggles after the latch edge and must be ignored
      if (n >= hold) drv(w, 1'b0, 1);
      else drv(w, 1'b1, 1);
      e = q.pop_front();
      chk($sformatf("%s c%0d", tag, n), 32'(obs(w)), 32'(e));
    end
    chk({tag, " drain"}, 32'(q.size()), 32'd0);
    q.delete();
  endtask

  initial begin
    errs   = 0;
    checks = 0;
    rst_n  = 1'b0;
    drv(1, 1'b0, 0);
    drv(3, 1'b0, 0);
    #12;
    chk("rst dut1", 32'(obs(1)), 32'd0);
    chk("rst dut3", 32'(obs(3)), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run("len4 lat1", 1, 4, 1, 1);
    run("len2 lat3", 3, 2, 1, 3);
    run("len0", 1, 0, 1, 1);
    run("len7 clamp", 1, 7, 1, 1);
    run("hold5", 1, 3, 5, 1);
    run("len1 lat1", 1, 1, 1, 1);
    run("len1 lat3 hold2", 3, 1, 2, 3);
    run("len0 lat3", 3, 0, 1, 3);

    // Asynchronous reset in the middle of a multiply.
    @(negedge clk);
    drv(3, 1'b1, 4);
    @(posedge clk);
    @(negedge clk);
    drv(3, 1'b0, 4);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("pre-rst mul_en", 32'(ifc3.mul_en), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async rst dut3", 32'(obs(3)), 32'd0);
    chk("async rst dut1", 32'(obs(1)), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run("post-rst len4 lat3", 3, 4, 1, 3);
    run("post-rst len4 lat1", 1, 4, 1, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
